inst_fetch_mem: RTL

//  Parametrised, loadable instruction memory with built-in fetch sequencer (PC, stall, flush, branch redirect).

---
 rtl/inst_fetch_mem_pkg.sv | 36 +++
 rtl/inst_ram_sp.sv | 46 ++++
 rtl/inst_fetch_mem.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_mem_pkg.sv
// Shared types for the instruction fetch memory: fetch FSM states, NOP encoding,
// and R-type opcode/function fields used to assemble program words.
package inst_fetch_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INST_NOP = 32'h0;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_SLT = 6'h2A
    } func_t;

    // {OPCODE,RS,RT,RD,SA,FUNC} with SA fixed at zero.
    function automatic logic [31:0] rtype(input func_t fn, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

endpackage

// File: rtl/inst_ram_sp.sv
// Single-port instruction array: synchronous write, registered read.
// With `INST_FETCH_PARITY_EN an even-parity bit is stored per word and rechecked on the read register.
module inst_ram_sp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_par_err
);

`ifdef INST_FETCH_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem_q [2**ADDR_W];
    logic [MEM_W-1:0] rd_q;
    logic [MEM_W-1:0] wr_word;

`ifdef INST_FETCH_PARITY_EN
    assign wr_word    = {^wr_data, wr_data};
    assign rd_par_err = ^rd_q;
`else
    assign wr_word    = wr_data;
    assign rd_par_err = 1'b0;
`endif

    assign rd_data = rd_q[DATA_W-1:0];

    // Array and read register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_word;
        end
        if (rd_en) begin
            rd_q <= mem_q[addr];
        end
    end

endmodule

// File: rtl/inst_fetch_mem.sv
// Loadable instruction memory with fetch sequencer (PC, stall, flush, branch redirect).
// Optional stored-word parity checking is enabled by defining `INST_FETCH_PARITY_EN.
module inst_fetch_mem
    import inst_fetch_mem_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    input  logic              stall,
    input  logic              flush,
    input  logic              br_taken,
    input  logic [31:0]       br_target,
    output logic [DATA_W-1:0] instruction,
    output logic [31:0]       pc_out,
    output logic              inst_valid,
    output logic [1:0]        state,
    output logic              addr_err,
    output logic              parity_err
);

    localparam logic [32:0] DEPTH_EXT = 33'd1 << ADDR_W;

    fetch_state_t      state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [DATA_W-1:0] instruction_q, instruction_d;
    logic [31:0]       pc_out_q, pc_out_d;
    logic              inst_valid_q, inst_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              parity_err_q, parity_err_d;

    logic              pc_q_oob;
    logic              pc_d_ok;
    logic              ram_we;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic              ram_par_err;

    assign pc_q_oob = ({1'b0, pc_q} >= DEPTH_EXT);
    assign pc_d_ok  = ({1'b0, pc_d} <  DEPTH_EXT);

    // The RAM is addressed with next-PC so its registered read lines up with pc_q,
    // leaving a full cycle for range/parity checks before the output register.
    assign ram_we    = (state_q == LOAD) && load_we;
    assign ram_addr  = (state_q == LOAD) ? load_addr : pc_d[ADDR_W-1:0];
    assign ram_rd_en = (state_q != LOAD) && pc_d_ok;

    inst_ram_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk        (clk),
        .we         (ram_we),
        .rd_en      (ram_rd_en),
        .addr       (ram_addr),
        .wr_data    (load_data),
        .rd_data    (ram_rd_data),
        .rd_par_err (ram_par_err)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruction_d = instruction_q;
        pc_out_d      = pc_out_q;
        inst_valid_d  = 1'b0;
        addr_err_d    = addr_err_q;
        parity_err_d  = parity_err_q;

        unique case (state_q)
            IDLE: begin
                if (load_en) begin
                    state_d = LOAD;
                end else if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (pc_q_oob) begin
                    state_d       = HALT;
                    instruction_d = DATA_W'(INST_NOP);
                    pc_out_d      = pc_q;
                    addr_err_d    = 1'b1;
                end else if (ram_par_err) begin
                    state_d       = HALT;
                    instruction_d = DATA_W'(INST_NOP);
                    pc_out_d      = pc_q;
                    parity_err_d  = 1'b1;
                end else begin
                    if (br_taken) begin
                        pc_d = br_target;
                    end else if (!stall) begin
                        pc_d = pc_q + 32'd1;
                    end

                    if (flush) begin
                        instruction_d = DATA_W'(INST_NOP);
                        pc_out_d      = pc_q;
                    end else if (stall && !br_taken) begin
                        inst_valid_d  = inst_valid_q;
                    end else begin
                        instruction_d = ram_rd_data;
                        pc_out_d      = pc_q;
                        inst_valid_d  = 1'b1;
                    end
                end
            end
            HALT: begin
                if (load_en) begin
                    state_d = LOAD;
                end else if (start) begin
                    state_d      = RUN;
                    pc_d         = RESET_PC;
                    addr_err_d   = 1'b0;
                    parity_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instruction_q <= '0;
            pc_out_q      <= '0;
            inst_valid_q  <= 1'b0;
            addr_err_q    <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            pc_out_q      <= pc_out_d;
            inst_valid_q  <= inst_valid_d;
            addr_err_q    <= addr_err_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign instruction = instruction_q;
    assign pc_out      = pc_out_q;
    assign inst_valid  = inst_valid_q;
    assign state       = state_q;
    assign addr_err    = addr_err_q;
    assign parity_err  = parity_err_q;

endmodule
